// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin sharing of one unsigned_to_bcd converter among N_CH requesters
module bcd_conv_scheduler #(
    parameter int N_CH    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_CH-1:0]      i_req,
    input  logic [32*N_CH-1:0]   i_value,
    output logic                 o_conv_trigger,
    output logic [31:0]          o_conv_in,
    input  logic                 i_conv_idle,
    input  logic [31:0]          i_conv_bcd,
    output logic [32*N_CH-1:0]   o_bcd_out,
    output logic [N_CH-1:0]      o_valid,
    output logic                 o_done,
    output logic [2:0]           o_done_ch,
    output logic                 o_error,
    output logic                 o_busy
);
    localparam logic [2:0] S_SELECT    = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_STORE     = 3'd4;
    localparam logic [2:0] S_ABORT     = 3'd5;

    logic [2:0]          r_state, w_next;
    logic [2:0]          r_ptr, r_cur;
    logic [N_CH-1:0]     r_pending, w_clr, w_rot;
    logic [15:0]         r_wd;
    logic                r_wb, r_trig, r_done, r_error, r_busy;
    logic [31:0]         r_conv_in, w_sel;
    logic [32*N_CH-1:0]  r_bcd;
    logic [N_CH-1:0]     r_valid;
    logic                w_found, w_end;
    logic [2:0]          w_off, w_grant;
    logic [3:0]          w_sum;

    // pending rotated so bit 0 is the channel at ptr; lowest set bit wins
    always_comb begin
        w_rot   = N_CH'({r_pending, r_pending} >> r_ptr);
        w_found = 1'b0;
        w_off   = 3'd0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 3'(k);
            end
        end
        w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
        w_grant = (w_sum >= 4'(N_CH)) ? 3'(w_sum - 4'(N_CH)) : w_sum[2:0];
        w_sel   = 32'd0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == 3'(k)) w_sel = i_value[32*k +: 32];
        end
    end

    always_comb begin
        w_next = S_SELECT;
        case (r_state)
            S_SELECT:    w_next = (w_found && i_conv_idle) ? S_ISSUE : S_SELECT;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: w_next = !i_conv_idle ? S_WAIT_DONE : (r_wb ? S_STORE : S_WAIT_BUSY);
            S_WAIT_DONE: w_next = i_conv_idle ? S_STORE :
                                  (r_wd == 16'(TIMEOUT - 1) ? S_ABORT : S_WAIT_DONE);
            default:     w_next = S_SELECT;
        endcase
    end

    assign w_end = (r_state == S_STORE) || (r_state == S_ABORT);
    assign w_clr = w_end ? (N_CH'(1) << r_cur) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_SELECT;
            r_ptr     <= 3'd0;
            r_cur     <= 3'd0;
            r_pending <= '0;
            r_wd      <= 16'd0;
            r_wb      <= 1'b0;
            r_trig    <= 1'b0;
            r_conv_in <= 32'd0;
            r_bcd     <= '0;
            r_valid   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= (r_pending & ~w_clr) | i_req;
            r_wb      <= r_state == S_WAIT_BUSY;
            r_wd      <= (r_state == S_WAIT_DONE) ? r_wd + 16'd1 : 16'd0;
            r_trig    <= w_next == S_ISSUE;
            r_done    <= w_next == S_STORE;
            r_error   <= w_next == S_ABORT;
            r_busy    <= w_next != S_SELECT;
            if (r_state == S_SELECT && w_next == S_ISSUE) begin
                r_conv_in <= w_sel;
                r_cur     <= w_grant;
            end
            if (w_end) r_ptr <= (r_cur == 3'(N_CH - 1)) ? 3'd0 : r_cur + 3'd1;
            // result lands together with the done pulse
            if (w_next == S_STORE) r_valid <= r_valid | (N_CH'(1) << r_cur);
            for (int k = 0; k < N_CH; k++) begin
                if (w_next == S_STORE && r_cur == 3'(k)) r_bcd[32*k +: 32] <= i_conv_bcd;
            end
        end
    end

    assign o_conv_trigger = r_trig;
    assign o_conv_in      = r_conv_in;
    assign o_bcd_out      = r_bcd;
    assign o_valid        = r_valid;
    assign o_done         = r_done;
    assign o_done_ch      = r_cur;
    assign o_error        = r_error;
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: converter model, transaction-level scheduler model and directed/random stimulus
module tb_bcd_conv_scheduler;
    localparam int N  = 3;
    localparam int TO = 40;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [32*N-1:0] value = '0;
    logic            conv_trigger, done, error, busy;
    logic [31:0]     conv_in;
    logic            cv_idle = 1'b1;
    logic [31:0]     cv_bcd = '0;
    logic [32*N-1:0] bcd_out;
    logic [N-1:0]    valid;
    logic [2:0]      done_ch;
    int              checks = 0, failures = 0, cyc = 0;

    bcd_conv_scheduler #(.N_CH(N), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_value(value),
        .o_conv_trigger(conv_trigger), .o_conv_in(conv_in),
        .i_conv_idle(cv_idle), .i_conv_bcd(cv_bcd),
        .o_bcd_out(bcd_out), .o_valid(valid), .o_done(done), .o_done_ch(done_ch),
        .o_error(error), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r = '0;
        logic [31:0] x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // converter: mode 0 finishes inside the handshake, 1 stays busy cv_lat cycles, 2 stalls until released
    int          cv_mode = 1, cv_lat = 34, cv_cnt = 0;
    bit          cv_release = 1'b0;
    logic [31:0] cv_op = '0;
    always @(posedge clk) begin
        if (conv_trigger === 1'b1) begin
            cv_op <= conv_in;
            if (cv_mode == 0) cv_bcd <= to_bcd(conv_in);
            else begin
                cv_idle <= 1'b0;
                cv_cnt  <= cv_lat;
            end
        end else if (!cv_idle) begin
            if (cv_mode == 2 ? cv_release : cv_cnt == 1) begin
                cv_idle <= 1'b1;
                cv_bcd  <= cv_mode == 2 ? 32'hDEAD_BEEF : to_bcd(cv_op);
            end else cv_cnt <= cv_cnt - 1;
        end
    end

    // scheduler model: one conversion at a time, with its trigger and end cycle predicted
    logic [N-1:0]    m_pend, clr;
    logic [32*N-1:0] m_bcd;
    logic [N-1:0]    m_valid;
    logic [31:0]     m_conv_in;
    int              m_ptr, m_cur, m_trig, m_end, lat;
    bit              m_act, m_err, is_end;
    int              tr_cyc[$], ev_cyc[$], ev_ch[$];
    logic [31:0]     tr_in[$], ev_bcd[$];
    bit              ev_err[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pend = '0; m_ptr = 0; m_cur = 0; m_act = 0; m_err = 0;
            m_trig = -1; m_end = -1; m_conv_in = '0; m_bcd = '0; m_valid = '0;
        end else begin
            if (m_act && cyc == m_trig) begin
                lat   = cv_mode == 0 ? 1 : (cv_mode == 2 ? 1000000 : cv_lat);
                m_err = lat > TO;
                m_end = m_err ? m_trig + 2 + TO : m_trig + lat + 2;
            end
            is_end = m_act && cyc == m_end;
            if (is_end && !m_err) begin
                m_bcd[32*m_cur +: 32] = to_bcd(m_conv_in);
                m_valid[m_cur] = 1'b1;
            end
            chk("trigger", conv_trigger, m_act && cyc == m_trig);
            chk("busy", busy, m_act && cyc >= m_trig);
            chk("done", done, is_end && !m_err);
            chk("error", error, is_end && m_err);
            if (is_end) chk("done_ch", done_ch, m_cur);
            chk("conv_in", conv_in, m_conv_in);
            chk("bcd_out", bcd_out, m_bcd);
            chk("valid", valid, m_valid);
            if (conv_trigger) begin
                tr_cyc.push_back(cyc);
                tr_in.push_back(conv_in);
            end
            if (done || error) begin
                ev_cyc.push_back(cyc);
                ev_ch.push_back(int'(done_ch));
                ev_err.push_back(error);
                ev_bcd.push_back(bcd_out[32*done_ch +: 32]);
            end
            clr = '0;
            if (is_end) begin
                clr[m_cur] = 1'b1;
                m_act = 0;
                m_ptr = (m_cur + 1) % N;
            end else if (!m_act && m_pend != '0 && cv_idle) begin
                for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
                m_conv_in = value[32*m_cur +: 32];
                m_act = 1;
                m_trig = cyc + 1;
                m_end = -1;
            end
            m_pend = (m_pend & ~clr) | req;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tr_cyc.delete(); tr_in.delete(); ev_cyc.delete(); ev_ch.delete(); ev_err.delete(); ev_bcd.delete();
    endtask

    task automatic wait_quiet(input int maxc);
        int k = 0;
        while ((busy || m_act || m_pend != '0 || !cv_idle) && k < maxc) begin
            tick(1);
            k++;
        end
        chk("quiet_timeout", k < maxc, 1'b1);
        tick(2);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_trigger"}, conv_trigger, 0);
        chk({nm, "_conv_in"}, conv_in, 0);
        chk({nm, "_bcd_out"}, bcd_out, 0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_done_ch"}, done_ch, 0);
        chk({nm, "_error"}, error, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    int              t0, k;
    logic [32*N-1:0] saved_bcd;
    logic [N-1:0]    saved_valid;

    initial begin
        tick(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick(2);

        value[31:0] = 32'd59; cv_mode = 1; cv_lat = 34; clear_logs();
        req = 3'b001; t0 = cyc; tick(1); req = '0;
        wait_quiet(200);
        chk("t1_ntrig", tr_cyc.size(), 1);
        chk("t1_trig_cyc", tr_cyc[0], t0 + 2);
        chk("t1_conv_in", tr_in[0], 59);
        chk("t1_ndone", ev_cyc.size(), 1);
        chk("t1_done_cyc", ev_cyc[0], t0 + 38);
        chk("t1_done_ch", ev_ch[0], 0);
        chk("t1_err", ev_err[0], 0);
        chk("t1_bcd", bcd_out[31:0], 32'h59);
        chk("t1_valid", valid, 3'b001);

        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        value = {32'd3, 32'd2, 32'd1}; cv_lat = 5; clear_logs();
        req = 3'b111; tick(1); req = '0;
        wait_quiet(300);
        chk("t2_ndone", ev_ch.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_order", ev_ch[i], i);
            chk("t2_conv_in", tr_in[i], i + 1);
        end
        chk("t2_bcd", bcd_out, {32'h3, 32'h2, 32'h1});
        chk("t2_valid", valid, 3'b111);

        cv_lat = 8; clear_logs();
        req = 3'b101; tick(1); req = 3'b001; k = 0;
        while (ev_ch.size() < 3 && k < 300) begin tick(1); k++; end
        req = '0;
        wait_quiet(300);
        chk("t3_first", ev_ch[0], 0);
        chk("t3_second", ev_ch[1], 2);
        chk("t3_third", ev_ch[2], 0);

        value[63:32] = 32'd7; cv_lat = 20; clear_logs();
        req = 3'b010; tick(1); req = '0; tick(8);
        value[63:32] = 32'd8; req = 3'b010; k = 0;
        while (!done && k < 100) begin tick(1); k++; end
        tick(1); req = '0;
        wait_quiet(300);
        chk("t4_ndone", ev_bcd.size(), 2);
        chk("t4_first", ev_bcd[0], 32'h7);
        chk("t4_second", ev_bcd[1], 32'h8);
        chk("t4_in_second", tr_in[1], 8);

        value[95:64] = 32'd1234; cv_lat = TO; clear_logs();
        req = 3'b100; tick(1); req = '0; wait_quiet(300);
        value[95:64] = 32'd4321; cv_lat = TO + 1;
        req = 3'b100; tick(1); req = '0; wait_quiet(300);
        chk("t5_nev", ev_cyc.size(), 2);
        chk("t5_at_limit_done", ev_err[0], 0);
        chk("t5_over_limit_err", ev_err[1], 1);
        chk("t5_err_lat", ev_cyc[1] - tr_cyc[1], TO + 2);
        chk("t5_err_ch", ev_ch[1], 2);
        chk("t5_bcd_kept", bcd_out[95:64], 32'h1234);

        saved_bcd = bcd_out; saved_valid = valid;
        cv_mode = 2; value[31:0] = 32'd77; clear_logs();
        req = 3'b001; tick(1); req = '0; k = 0;
        while (ev_cyc.size() == 0 && k < 300) begin tick(1); k++; end
        chk("t6_err", ev_err[0], 1);
        chk("t6_ch", ev_ch[0], 0);
        chk("t6_lat", ev_cyc[0] - tr_cyc[0], TO + 2);
        tick(5);
        chk("t6_bcd_kept", bcd_out, saved_bcd);
        chk("t6_valid_kept", valid, saved_valid);
        chk("t6_no_regrant", tr_cyc.size(), 1);
        cv_release = 1'b1; tick(2); cv_release = 1'b0; cv_mode = 1;
        wait_quiet(100);

        cv_lat = 30; value[63:32] = 32'd99;
        req = 3'b010; tick(1); req = '0; tick(10);
        chk("t7_busy_before", busy, 1);
        rst_n = 1'b0; #1;
        chk_reset_outputs("t7");
        tick(2); rst_n = 1'b1; clear_logs();
        tick(40);
        chk("t7_no_events", ev_cyc.size(), 0);
        wait_quiet(100);

        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 3) == 0) value[32*$urandom_range(0, N-1) +: 32] = $urandom_range(0, 99999999);
            if ($urandom_range(0, 15) == 0) begin
                cv_mode = $urandom_range(0, 1);
                cv_lat  = $urandom_range(1, TO + 4);
            end
            tick(1);
        end
        req = '0;
        wait_quiet(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
